adc_capture: RTL

Serial ADC reader forming the measurement side of the electrochemical workstation. While the waveform core drives the excitation DAC, this block clocks samples out of a serial SPI-style ADC, averages 2^AVG_LOG2 consecutive conversions, and presents one averaged word with a single-cycle valid strobe. It runs in single-shot or continuous mode, using the same Out_Mode convention as the waveform core.

---
 rtl/adc_capture.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_capture.sv
// adc_capture: serial ADC reader with frame averaging.
//
// Runs SPI-style frames against a serial ADC. The leading N_LEAD bits of each
// frame are ignored. The following ND_ADC bits are shifted in MSB first.
// 2^AVG_LOG2 frames are summed, and the truncated mean is presented on
// data_out together with a one-cycle data_valid strobe.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-low
//   en         block enable; dropping it mid-frame finishes the frame and
//              discards the partial set
//   Out_Mode   1 = one averaged word per trig, 0 = continuous while en
//   trig       single-mode start pulse, only looked at in IDLE
//   adc_sdo    serial data from the ADC, MSB first
//   adc_cs_n   ADC chip select, active-low
//   adc_sclk   ADC serial clock, idles low
//   data_out   latest averaged sample
//   data_valid one-cycle strobe marking a new data_out
//   busy       high whenever the controller is not in IDLE
module adc_capture #(
  parameter int ND_ADC   = 16,
  parameter int N_LEAD   = 6,
  parameter int CLK_DIV  = 2,
  parameter int N_QUIET  = 4,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              Out_Mode,
  input  logic              trig,
  input  logic              adc_sdo,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [ND_ADC-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  localparam int N_BITS = N_LEAD + ND_ADC;
  localparam int ACC_W  = ND_ADC + AVG_LOG2;
  localparam int N_AVG  = 1 << AVG_LOG2;
  localparam int TMAX   = (CLK_DIV > N_QUIET) ? CLK_DIV : N_QUIET;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int BW     = $clog2(N_BITS + 1);
  localparam int FW     = AVG_LOG2 + 1;

  localparam logic [TW-1:0] DIV_LAST   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] QUIET_LAST = TW'(N_QUIET - 1);
  localparam logic [BW-1:0] BIT_LEAD   = BW'(N_LEAD);
  localparam logic [BW-1:0] BIT_FULL   = BW'(N_BITS);
  localparam logic [FW-1:0] FRM_FULL   = FW'(N_AVG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_QUIET,
    S_OUT
  } state_t;

  state_t              state_q;
  logic [TW-1:0]       tmr_q;
  logic [BW-1:0]       bit_q;
  logic [FW-1:0]       frm_q;
  logic [ND_ADC-1:0]   shift_q;
  logic [ACC_W-1:0]    acc_q;
  logic                mode_q;
  logic                abort_q;
  logic                cs_n_q;
  logic                sclk_q;
  logic [ND_ADC-1:0]   data_q;
  logic                valid_q;
  logic                busy_q;

  logic [ACC_W-1:0]    acc_d;

  // Truncating mean: drop the AVG_LOG2 fraction bits of the sum.
  function automatic logic [ND_ADC-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
    return sum[ACC_W-1:AVG_LOG2];
  endfunction

  // The accumulator is wide enough for N_AVG full-scale words, so no wrap.
  assign acc_d = acc_q + ACC_W'(shift_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      frm_q   <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      mode_q  <= 1'b0;
      abort_q <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // Once en drops during an acquisition, the set is dead. The frame
      // in flight still runs to completion so that cs_n is never cut short.
      if (state_q != S_IDLE && !en) begin
        abort_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          if (en && (!Out_Mode || trig)) begin
            mode_q  <= Out_Mode;
            state_q <= S_LOW;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            tmr_q   <= '0;
            bit_q   <= '0;
            frm_q   <= '0;
            acc_q   <= '0;
          end
        end

        S_LOW: begin
          if (tmr_q == DIV_LAST) begin
            // sclk rising edge: sample sdo in the same cycle sclk goes high
            tmr_q   <= '0;
            state_q <= S_HIGH;
            sclk_q  <= 1'b1;
            bit_q   <= bit_q + BW'(1);
            if (bit_q >= BIT_LEAD) begin
              shift_q <= {shift_q[ND_ADC-2:0], adc_sdo};
            end
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end

        S_HIGH: begin
          if (tmr_q == DIV_LAST) begin
            tmr_q  <= '0;
            sclk_q <= 1'b0;
            if (bit_q == BIT_FULL) begin
              state_q <= S_QUIET;
              cs_n_q  <= 1'b1;
              bit_q   <= '0;
              acc_q   <= acc_d;
              frm_q   <= frm_q + FW'(1);
            end else begin
              state_q <= S_LOW;
            end
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end

        S_QUIET: begin
          if (tmr_q == QUIET_LAST) begin
            tmr_q <= '0;
            if (abort_q || !en) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              acc_q   <= '0;
              frm_q   <= '0;
              abort_q <= 1'b0;
            end else if (frm_q == FRM_FULL) begin
              state_q <= S_OUT;
            end else begin
              state_q <= S_LOW;
              cs_n_q  <= 1'b0;
            end
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end

        S_OUT: begin
          data_q  <= avg_trunc(acc_q);
          valid_q <= 1'b1;
          acc_q   <= '0;
          frm_q   <= '0;
          abort_q <= 1'b0;
          if (!mode_q && en) begin
            state_q <= S_LOW;
            cs_n_q  <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign adc_cs_n   = cs_n_q;
  assign adc_sclk   = sclk_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;

endmodule
